// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// The optional misaligned-access trap is enabled with `define LSU_MISALIGN_TRAP_EN;
// the helper below is only referenced when that macro is defined.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_t;

  // Load encodings of func3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store encodings of func3
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // True when the access cannot be served by a single naturally aligned container.
  // Unlisted func3 values behave as word accesses, so they need both low bits clear.
  function automatic logic is_misaligned(input logic       is_store,
                                         input logic [2:0] f3,
                                         input logic [1:0] lo);
    logic mis;
    mis = (lo != 2'b00);
    if (is_store) begin
      case (f3)
        F3_SB:   mis = 1'b0;
        F3_SH:   mis = lo[0];
        default: mis = (lo != 2'b00);
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LBU: mis = 1'b0;
        F3_LH, F3_LHU: mis = lo[0];
        default:       mis = (lo != 2'b00);
      endcase
    end
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit.
// Store side replicates the store value across lanes and builds byte enables;
// load side picks the addressed byte/half out of the read word and extends it.
import lsu_pkg::*;

module lsu_align (
  input  logic [31:0] store_data,
  input  logic [2:0]  st_func3,
  input  logic [1:0]  st_addr_lo,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic [31:0] rsp_rdata,
  input  logic [2:0]  ld_func3,
  input  logic [1:0]  ld_addr_lo,
  output logic [31:0] load_ext
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Store lane replication and byte enables; anything not SB/SH is a full word
  always_comb begin
    wdata = store_data;
    wstrb = 4'b1111;
    case (st_func3)
      F3_SB: begin
        wdata = {4{store_data[7:0]}};
        wstrb = 4'b0001 << st_addr_lo;
      end
      F3_SH: begin
        wdata = {2{store_data[15:0]}};
        wstrb = 4'b0011 << {st_addr_lo[1], 1'b0};
      end
      default: begin
        wdata = store_data;
        wstrb = 4'b1111;
      end
    endcase
  end

  // Select the addressed byte of the read word
  always_comb begin
    lane_byte = rsp_rdata[7:0];
    case (ld_addr_lo)
      2'd0: lane_byte = rsp_rdata[7:0];
      2'd1: lane_byte = rsp_rdata[15:8];
      2'd2: lane_byte = rsp_rdata[23:16];
      2'd3: lane_byte = rsp_rdata[31:24];
      default: lane_byte = rsp_rdata[7:0];
    endcase
  end

  assign lane_half = ld_addr_lo[1] ? rsp_rdata[31:16] : rsp_rdata[15:0];

  // Extend the selected lane; reserved load encodings return the whole word
  always_comb begin
    load_ext = rsp_rdata;
    case (ld_func3)
      F3_LB:   load_ext = {{24{lane_byte[7]}}, lane_byte};
      F3_LH:   load_ext = {{16{lane_half[15]}}, lane_half};
      F3_LBU:  load_ext = {24'h000000, lane_byte};
      F3_LHU:  load_ext = {16'h0000, lane_half};
      default: load_ext = rsp_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit sitting behind the ALU of the single-cycle core.
// Runs one valid/ready request per memory instruction and stalls the core until
// the response arrives; the core retires the instruction in the DONE cycle.
// Optional: `define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses
// instead of silently using the aligned container.
import lsu_pkg::*;

module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        func3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              misaligned,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_we,
  output logic [ADDR_W-1:0] req_addr,
  output logic [31:0]       req_wdata,
  output logic [3:0]        req_wstrb,
  input  logic              rsp_valid,
  input  logic [31:0]       rsp_rdata
);

  lsu_state_t  state;
  lsu_state_t  next_state;

  logic        op_start;
  logic        mis_now;
  logic        op_we;
  logic        op_mis;
  logic [2:0]  op_func3;
  logic [1:0]  op_addr_lo;

  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [31:0] ld_ext;

  assign op_start = mem_read | mem_write;

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_now = is_misaligned(mem_write, func3, addr[1:0]);
`else
  assign mis_now = 1'b0;
`endif

  // Store lanes come from the live inputs (registered at issue); load lanes use the
  // func3/offset latched at issue since the core inputs are not trusted later.
  lsu_align u_align (
    .store_data (store_data),
    .st_func3   (func3),
    .st_addr_lo (addr[1:0]),
    .wdata      (st_wdata),
    .wstrb      (st_wstrb),
    .rsp_rdata  (rsp_rdata),
    .ld_func3   (op_func3),
    .ld_addr_lo (op_addr_lo),
    .load_ext   (ld_ext)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake/status outputs
  always_comb begin
    next_state = state;
    stall      = 1'b0;
    req_valid  = 1'b0;
    load_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        stall = op_start;
        if (op_start) begin
          next_state = mis_now ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        stall     = 1'b1;
        req_valid = 1'b1;
        if (req_ready) begin
          next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (rsp_valid) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        load_valid = ~op_we & ~op_mis;
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = (state == ST_DONE) & op_mis;
`else
  assign misaligned = 1'b0;
`endif

  // Latch the operation and request fields at issue; capture load results in WAIT
  always_ff @(posedge clk) begin
    if (reset) begin
      op_we      <= 1'b0;
      op_mis     <= 1'b0;
      op_func3   <= 3'b000;
      op_addr_lo <= 2'b00;
      req_we     <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= 32'h0;
      req_wstrb  <= 4'h0;
      load_data  <= 32'h0;
    end else begin
      if (state == ST_IDLE && op_start) begin
        op_we      <= mem_write;
        op_mis     <= mis_now;
        op_func3   <= func3;
        op_addr_lo <= addr[1:0];
        if (!mis_now) begin
          req_we    <= mem_write;
          req_addr  <= {addr[ADDR_W-1:2], 2'b00};
          req_wdata <= mem_write ? st_wdata : 32'h0;
          req_wstrb <= mem_write ? st_wstrb : 4'h0;
        end
      end
      if (state == ST_WAIT && rsp_valid && !op_we) begin
        load_data <= ld_ext;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with hand-computed expectations.
// Honours `define LSU_MISALIGN_TRAP_EN to select the expected misaligned behaviour.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misaligned;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;

  int error_count = 0;
  int check_count = 0;

  // Observations from the most recent transaction
  int          obs_stall_cycles;
  int          obs_done_cycle;
  logic        obs_done_seen;
  logic        obs_saw_req;
  logic        obs_req_stable;
  logic        obs_req_we;
  logic [31:0] obs_req_addr;
  logic [31:0] obs_req_wdata;
  logic [3:0]  obs_req_wstrb;
  logic        obs_load_valid;
  logic [31:0] obs_load_data;
  logic        obs_misaligned;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .func3      (func3),
    .addr       (addr),
    .store_data (store_data),
    .stall      (stall),
    .load_data  (load_data),
    .load_valid (load_valid),
    .misaligned (misaligned),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded loops
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Issue one memory instruction and act as the memory, with ready_delay cycles of
  // req_ready low and rsp_delay cycles before rsp_valid. Called #1 after a rising edge
  // with the DUT in IDLE; returns #1 after the edge that leaves DONE.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] sd,
                               input logic [31:0] rdata, input int ready_delay,
                               input int rsp_delay);
    int req_cnt;
    int wait_cnt;
    req_cnt          = 0;
    wait_cnt         = 0;
    obs_stall_cycles = 0;
    obs_done_cycle   = 0;
    obs_done_seen    = 1'b0;
    obs_saw_req      = 1'b0;
    obs_req_stable   = 1'b1;
    obs_req_we       = 1'b0;
    obs_req_addr     = 32'h0;
    obs_req_wdata    = 32'h0;
    obs_req_wstrb    = 4'h0;
    obs_load_valid   = 1'b0;
    obs_load_data    = 32'h0;
    obs_misaligned   = 1'b0;
    mem_read   = rd;
    mem_write  = wr;
    func3      = f3;
    addr       = a;
    store_data = sd;
    rsp_rdata  = rdata;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    #1;
    for (int cyc = 1; cyc <= 40 && !obs_done_seen; cyc++) begin
      if (req_valid) begin
        if (!obs_saw_req) begin
          obs_req_we    = req_we;
          obs_req_addr  = req_addr;
          obs_req_wdata = req_wdata;
          obs_req_wstrb = req_wstrb;
        end else if (req_we !== obs_req_we || req_addr !== obs_req_addr ||
                     req_wdata !== obs_req_wdata || req_wstrb !== obs_req_wstrb) begin
          obs_req_stable = 1'b0;
        end
        obs_saw_req = 1'b1;
        if (stall) obs_stall_cycles++;
        rsp_valid = 1'b0;
        req_ready = (req_cnt >= ready_delay);
        req_cnt++;
      end else if (stall) begin
        obs_stall_cycles++;
        if (obs_saw_req) begin
          req_ready = 1'b0;
          rsp_valid = (wait_cnt >= rsp_delay);
          wait_cnt++;
        end
      end else if (cyc > 1) begin
        obs_done_seen  = 1'b1;
        obs_done_cycle = cyc;
        obs_load_valid = load_valid;
        obs_load_data  = load_data;
        obs_misaligned = misaligned;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("done_reached", 32'(obs_done_seen), 32'h1);
  endtask

  initial begin
    reset      = 1'b1;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    func3      = 3'b000;
    addr       = 32'h0;
    store_data = 32'h0;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_rdata  = 32'h0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    checkOutput("rst_req_valid",  32'(req_valid),  32'h0);
    checkOutput("rst_stall",      32'(stall),      32'h0);
    checkOutput("rst_load_valid", 32'(load_valid), 32'h0);
    checkOutput("rst_misaligned", 32'(misaligned), 32'h0);
    checkOutput("rst_req_we",     32'(req_we),     32'h0);
    checkOutput("rst_req_addr",   req_addr,        32'h0);
    checkOutput("rst_req_wdata",  req_wdata,       32'h0);
    checkOutput("rst_req_wstrb",  32'(req_wstrb),  32'h0);
    checkOutput("rst_load_data",  load_data,       32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle_stall", 32'(stall), 32'h0);

    // LB from lane 3, sign-extended, minimum latency
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 0);
    checkOutput("lb_data",       obs_load_data,          32'hFFFF_FF80);
    checkOutput("lb_valid",      32'(obs_load_valid),    32'h1);
    checkOutput("lb_done_cycle", obs_done_cycle,         32'd4);
    checkOutput("lb_stall",      obs_stall_cycles,       32'd3);
    checkOutput("lb_req_addr",   obs_req_addr,           32'h0000_0100);
    checkOutput("lb_req_we",     32'(obs_req_we),        32'h0);
    checkOutput("lb_req_wstrb",  32'(obs_req_wstrb),     32'h0);

    // SH to upper half
    applyStimulus(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 32'h0, 0, 0);
    checkOutput("sh_wdata",   obs_req_wdata,        32'hBEEF_BEEF);
    checkOutput("sh_wstrb",   32'(obs_req_wstrb),   32'hC);
    checkOutput("sh_addr",    obs_req_addr,         32'h0000_0200);
    checkOutput("sh_we",      32'(obs_req_we),      32'h1);
    checkOutput("sh_no_load", 32'(obs_load_valid),  32'h0);

    // LHU with back-pressure and slow response
    applyStimulus(1'b1, 1'b0, 3'b101, 32'h0, 32'h0, 32'h0000_8001, 3, 2);
    checkOutput("lhu_data",   obs_load_data,        32'h0000_8001);
    checkOutput("lhu_stall",  obs_stall_cycles,     32'd8);
    checkOutput("lhu_done",   obs_done_cycle,       32'd9);
    checkOutput("lhu_stable", 32'(obs_req_stable),  32'h1);

    // Read and write together: store wins, load_data untouched
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 32'h1111_1111, 1, 1);
    checkOutput("rw_we",      32'(obs_req_we),      32'h1);
    checkOutput("rw_wstrb",   32'(obs_req_wstrb),   32'hF);
    checkOutput("rw_wdata",   obs_req_wdata,        32'hCAFE_F00D);
    checkOutput("rw_no_load", 32'(obs_load_valid),  32'h0);
    checkOutput("rw_ld_hold", obs_load_data,        32'h0000_8001);

    // SB to lane 1
    applyStimulus(1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h1234_56A5, 32'h0, 0, 0);
    checkOutput("sb_wdata", obs_req_wdata,      32'hA5A5_A5A5);
    checkOutput("sb_wstrb", 32'(obs_req_wstrb), 32'h2);

    // Store with reserved func3 behaves as SW
    applyStimulus(1'b0, 1'b1, 3'b111, 32'h0000_0300, 32'h0BAD_F00D, 32'h0, 0, 0);
    checkOutput("s111_wstrb", 32'(obs_req_wstrb), 32'hF);
    checkOutput("s111_wdata", obs_req_wdata,      32'h0BAD_F00D);

    // LH upper half, sign-extended
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 0, 0);
    checkOutput("lh_data", obs_load_data, 32'hFFFF_8001);

    // LBU lane 1, zero-extended
    applyStimulus(1'b1, 1'b0, 3'b100, 32'h0000_0001, 32'h0, 32'h0000_F200, 0, 0);
    checkOutput("lbu_data", obs_load_data, 32'h0000_00F2);

    // Reserved load func3 011 behaves as LW
    applyStimulus(1'b1, 1'b0, 3'b011, 32'h0000_0020, 32'h0, 32'h89AB_CDEF, 0, 0);
    checkOutput("l011_data", obs_load_data, 32'h89AB_CDEF);

    // LW at a non-word address
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'h5555_AAAA, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    checkOutput("mis_no_req",  32'(obs_saw_req),    32'h0);
    checkOutput("mis_flag",    32'(obs_misaligned), 32'h1);
    checkOutput("mis_cycle",   obs_done_cycle,      32'd2);
    checkOutput("mis_no_load", 32'(obs_load_valid), 32'h0);
    checkOutput("mis_ld_hold", obs_load_data,       32'h89AB_CDEF);
    checkOutput("mis_stall",   obs_stall_cycles,    32'd1);
`else
    checkOutput("lw6_addr",  obs_req_addr,        32'h0000_0004);
    checkOutput("lw6_data",  obs_load_data,       32'h5555_AAAA);
    checkOutput("lw6_flag",  32'(obs_misaligned), 32'h0);
    checkOutput("lw6_valid", 32'(obs_load_valid), 32'h1);
`endif

    // Reset while waiting for the response
    mem_read  = 1'b1;
    mem_write = 1'b0;
    func3     = 3'b010;
    addr      = 32'h0000_0040;
    @(posedge clk);
    #1;
    checkOutput("rw_in_req", 32'(req_valid), 32'h1);
    req_ready = 1'b1;
    @(posedge clk);
    #1;
    req_ready = 1'b0;
    checkOutput("rw_in_wait_stall", 32'(stall),     32'h1);
    checkOutput("rw_in_wait_req",   32'(req_valid), 32'h0);
    reset    = 1'b1;
    mem_read = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("rst_wait_req_valid", 32'(req_valid), 32'h0);
    checkOutput("rst_wait_stall",     32'(stall),     32'h0);
    rsp_rdata = 32'hDEAD_BEEF;
    rsp_valid = 1'b1;
    @(posedge clk);
    #1;
    rsp_valid = 1'b0;
    checkOutput("late_rsp_valid", 32'(load_valid), 32'h0);
    checkOutput("late_rsp_stall", 32'(stall),      32'h0);
    checkOutput("late_rsp_data",  load_data,       32'h0);
    @(posedge clk);
    #1;
    checkOutput("late_rsp_valid2", 32'(load_valid), 32'h0);

    // Normal operation resumes after the abandoned access
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0044, 32'h0, 32'h0F0F_1234, 0, 0);
    checkOutput("post_rst_data", obs_load_data, 32'h0F0F_1234);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit placed directly downstream of the ALU in the single-cycle RV32I core. It takes the ALU result as the effective address and `MemRead`/`MemWrite`/`func3` from the decode controller, and runs a valid/ready transaction to the data memory. It freezes the core with `stall` until the access completes, then returns sign- or zero-extended load data for the write-back mux (`memtoReg`).

## Interface
- `ADDR_W`, default 32: effective-address width; `req_addr` width.
- Data width is fixed at 32; no parameter.

- `clk` in 1: core clock. One clock; all state is updated on the rising edge.
- `reset` in 1: synchronous, active-high.
- `mem_read` in 1: load request from the decode controller.
- `mem_write` in 1: store request from the decode controller.
- `func3` in 3: access size and sign.
- `addr` in ADDR_W: effective address (ALU result).
- `store_data` in 32: rs2 value.
- `stall` out 1: core must hold PC and suppress the register write.
- `load_data` out 32: extended load result.
- `load_valid` out 1: `load_data` is valid this cycle.
- `misaligned` out 1: misaligned-access trap pulse.
- `req_valid` out 1: memory request valid.
- `req_ready` in 1: memory accepts the request.
- `req_we` out 1: 1 = store.
- `req_addr` out ADDR_W: word-aligned address, with `addr[1:0]` forced to 0.
- `req_wdata` out 32: lane-replicated store data.
- `req_wstrb` out 4: byte enables. Forced to 0 for loads.
- `rsp_valid` in 1: memory response. Sent for both loads and stores.
- `rsp_rdata` in 32: read word.

## Operation
- FSM states:
  - IDLE
    - `mem_write` or `mem_read` asserted: latch the operation, address and data, then go to REQ.
    - `mem_write` and `mem_read` both asserted: the store wins.
    - No operation: stay in IDLE.
  - REQ: `req_valid`=1. On `req_ready`=1, go to WAIT.
  - WAIT: on `rsp_valid`=1, register the extended `rsp_rdata` into `load_data` (loads only), then go to DONE.
  - DONE: one cycle. `stall`=0. `load_valid`=1 for loads. The core completes the instruction here. Next state is always IDLE.
- Operation inputs are ignored in DONE, so the same instruction is not reissued.
- `stall` = (IDLE & (`mem_read` | `mem_write`)) | REQ | WAIT. `stall` is combinational.
- Request fields are registered. They are stable throughout REQ and do not change while `req_valid`=1 and `req_ready`=0.
- Load `func3` encodings:
  - 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - 011, 110, 111 perform LW.
- Store `func3` encodings:
  - 000 SB, 001 SH, 010 SW.
  - Any other value performs SW.
- Store lanes:
  - SB: `wstrb` = 0001 << `addr[1:0]`; `wdata` = {4{byte}}.
  - SH: `wstrb` = 0011 << {`addr[1]`, 1'b0}; `wdata` = {2{half}}.
  - SW: `wstrb` = 1111.
- Load extraction:
  - Byte lane selected by `addr[1:0]`; half lane selected by `addr[1]`.
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
- `load_data` holds its value until the next load response.
- `rsp_valid` outside WAIT is ignored.

## Timing
- Reset values: state IDLE; `req_valid`, `req_we`, `load_valid`, `misaligned` = 0; `req_addr`, `req_wdata`, `req_wstrb`, `load_data` = 0.
- Reset mid-transaction returns to IDLE the next edge and abandons any outstanding request. The data memory shares the same `reset`.
- Minimum access time, with `req_ready` and `rsp_valid` both immediate, is 4 cycles: IDLE, REQ, WAIT, DONE. `stall` is high for the first 3.
- Each cycle `req_ready` is low adds one REQ cycle; each cycle without `rsp_valid` adds one WAIT cycle.
- The memory must not assert `rsp_valid` in the same cycle it accepts the request.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned access is LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠0.
  - It goes IDLE→DONE with no memory request and 1 cycle of `stall`.
  - In DONE: `misaligned`=1, `load_valid`=0, `load_data` unchanged.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - `misaligned` is tied to 0.
  - Unused low address bits are ignored; the access hits the aligned container.

## Structure
- `lsu_pkg`:
  - FSM state enum.
  - `func3` constants: LB, LH, LW, LBU, LHU, SB, SH, SW.
- Sub-module `lsu_align`, combinational:
  - Store side: `store_data`, `func3`, `addr[1:0]` → `wdata`, `wstrb`.
  - Load side: `rsp_rdata`, `func3`, `addr[1:0]` → extended load data.

## Test plan
- LB, `addr`=0x103, `rsp_rdata`=0x80FF_1234 → `load_data`=0xFFFF_FF80, `load_valid` in cycle 4, `stall` high cycles 1–3.
- SH, `addr`=0x202, `store_data`=0x0000_BEEF → `req_wdata`=0xBEEF_BEEF, `req_wstrb`=1100, `req_addr`=0x200, `req_we`=1.
- LHU, `addr`=0x0, `rsp_rdata`=0x0000_8001, `req_ready` low for 3 cycles, `rsp_valid` delayed 2 cycles → `load_data`=0x0000_8001, `stall` high for 8 cycles.
- `mem_read`=`mem_write`=1 with SW, `addr`=0x10 → store issued (`req_we`=1, `wstrb`=1111), no load.
- `reset` asserted in WAIT → next cycle IDLE, `req_valid`=0, `stall`=0; a late `rsp_valid` is ignored.
- With `LSU_MISALIGN_TRAP_EN`, LW `addr`=0x6 → no `req_valid`, `misaligned`=1 in cycle 2, `load_valid`=0. Without the macro → `req_addr`=0x4, normal load.
